my_rom_loader: RTL
==================

// Module: my_rom_loader
// PURPOSE
//  Boot-time instruction-ROM loader that sits directly upstream of my_cpu.
//  Receives a program as a byte stream over a valid/ready handshake and assembles
//  16-bit Hack instructions, which it writes sequentially into instruction ROM.
//  Verifies a 16-bit checksum and holds the CPU in reset until a load succeeds.
//  When cpu_reset falls, my_cpu starts fetching at pc=0 from a freshly loaded ROM.
// PARAMETERS
//  ADDR_W  15  ROM address width; the maximum program is 2**ADDR_W words.
// PORTS
//  clk          in   1         system clock; all state changes on its rising edge
//  reset        in   1         asynchronous, active-high reset
//  start        in   1         1-cycle pulse; begins a new load from IDLE, DONE or ERR
//  rx_data      in   8         stream byte
//  rx_valid     in   1         rx_data is valid
//  rx_ready     out  1         loader accepts a byte this cycle
//  rom_addr     out  ADDR_W    ROM write address
//  rom_data     out  16        ROM write data (one instruction)
//  rom_we       out  1         ROM write strobe, exactly 1 cycle per word
//  cpu_reset    out  1         drives my_cpu reset; 1 unless state is DONE
//  busy         out  1         a load is in progress
//  done         out  1         last load succeeded (state DONE)
//  error        out  1         last load failed (state ERR)
//  words_loaded out  ADDR_W+1  number of words written in the current/last load
// BEHAVIOUR
//  Stream format: LEN_HI LEN_LO {W_HI W_LO}xLEN SUM_HI SUM_LO (big-endian).
//  - A byte transfers on a rising edge where rx_valid=1 and rx_ready=1.
//  - SUM = sum mod 2**16 of all LEN data words.
//  Asynchronous reset forces state=IDLE with these output values:
//  - cpu_reset=1, rx_ready=0, rom_we=0, busy=0, done=0, error=0.
//  - rom_addr=0, rom_data=0, words_loaded=0; internal sum=0, len=0.
//  State machine (all outputs are registered or decoded from state only):
//  - IDLE: start=1 -> LEN_HI; clear addr, sum and words_loaded.
//  - LEN_HI, LEN_LO: latch the two length bytes.
//    - After LEN_LO, if len > 2**ADDR_W -> ERR.
//    - After LEN_LO, if len == 0 -> SUM_HI.
//    - Otherwise -> DATA_HI.
//  - DATA_HI: latch the high byte. DATA_LO: latch the low byte -> WRITE.
//  - WRITE: 1 cycle with rom_we=1 and rx_ready=0; rom_addr and rom_data are stable.
//    - On exit: addr+1, words_loaded+1, sum+=word.
//    - If words_loaded+1 == len -> SUM_HI, else -> DATA_HI.
//  - SUM_HI, SUM_LO: latch the received checksum.
//    - After SUM_LO: match -> DONE, mismatch -> ERR.
//  - DONE: cpu_reset=0, done=1. start=1 -> LEN_HI with counters cleared; cpu_reset=1 again.
//  - ERR: error=1, cpu_reset=1. start=1 -> LEN_HI with counters cleared; error clears.
//  - rx_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, SUM_HI, SUM_LO.
//  - busy=1 in every state except IDLE, DONE and ERR.
//  Cycle timing and boundary rules:
//  - With rx_valid held high, a load of N words takes 2+3N+2 cycles from the first
//    accepted byte to the DONE entry edge.
//  - start is ignored while busy=1.
//  - rx_valid outside a receive state is not consumed; bytes are never dropped or duplicated.
//  - rom_addr wraps only at len == 2**ADDR_W: the final write is to 2**ADDR_W-1, and
//    words_loaded reaches 2**ADDR_W without overflow (ADDR_W+1 bits wide).
//  - Reset mid-load aborts immediately: rom_we drops asynchronously and no further
//    writes occur. Partially written ROM contents are not cleared.
//  - Checksum arithmetic is 16-bit unsigned and drops the carry out.
// TESTING
//  - Reset, then start with stream 00 02 | 12 34 | AB CD | BE 01:
//    rom_we at addr 0 data 1234, then addr 1 data ABCD; DONE, cpu_reset=0, words_loaded=2.
//  - Same program with checksum BE 02: no DONE; ERR, error=1, cpu_reset stays 1;
//    ROM still received both writes.
//  - Length 00 00 followed by 00 00: DONE with zero writes; length 80 01 (ADDR_W=15):
//    ERR directly after LEN_LO, no rom_we.
//  - rx_valid toggled randomly (about 50%) over a 64-word random program:
//    ROM contents match the input exactly, one rom_we per word, rx_ready=0 in every WRITE cycle.
//  - Assert reset while in DATA_LO of word 3: all outputs take reset values in the same
//    cycle; a subsequent start and full stream loads correctly.
//  - start pulses while busy are ignored.
//  - start pulse in DONE: cpu_reset rises on the next cycle and a second program loads
//    from addr 0.

Source files
------------

// File: rtl/my_rom_loader.sv
// Boot loader: assembles a byte stream into 16-bit words, writes them to
// instruction ROM, verifies a checksum and releases cpu_reset on success.
module my_rom_loader #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_data,
  output logic              rom_we,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_SUM_HI,
    S_SUM_LO,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] MAX_LEN = 32'd1 << ADDR_W;

  state_t      state;
  logic [15:0] len;
  logic [15:0] sum;
  logic [7:0]  sum_hi;
  logic        xfer;
  logic [15:0] len_full;
  logic [31:0] wl_inc;

  assign xfer     = rx_valid && rx_ready;
  assign len_full = {len[15:8], rx_data};
  assign wl_inc   = 32'(words_loaded) + 32'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      len          <= '0;
      sum          <= '0;
      sum_hi       <= '0;
      rom_addr     <= '0;
      rom_data     <= '0;
      words_loaded <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_LEN_HI;
            len          <= '0;
            sum          <= '0;
            rom_addr     <= '0;
            words_loaded <= '0;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len[15:8] <= rx_data;
            state     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len[7:0] <= rx_data;
            if (32'(len_full) > MAX_LEN)
              state <= S_ERR;
            else if (len_full == 16'd0)
              state <= S_SUM_HI;
            else
              state <= S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          if (xfer) begin
            rom_data[15:8] <= rx_data;
            state          <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (xfer) begin
            rom_data[7:0] <= rx_data;
            state         <= S_WRITE;
          end
        end
        S_WRITE: begin
          // rom_addr wraps to 0 only after a full 2**ADDR_W word load
          rom_addr     <= rom_addr + ADDR_W'(1);
          words_loaded <= words_loaded + (ADDR_W+1)'(1);
          sum          <= sum + rom_data;
          state        <= (wl_inc == 32'(len)) ? S_SUM_HI : S_DATA_HI;
        end
        S_SUM_HI: begin
          if (xfer) begin
            sum_hi <= rx_data;
            state  <= S_SUM_LO;
          end
        end
        S_SUM_LO: begin
          if (xfer)
            state <= ({sum_hi, rx_data} == sum) ? S_DONE : S_ERR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_ready  = 1'b0;
    rom_we    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    cpu_reset = 1'b1;
    unique case (state)
      S_LEN_HI, S_LEN_LO, S_DATA_HI,
      S_DATA_LO, S_SUM_HI, S_SUM_LO: rx_ready = 1'b1;
      S_WRITE: rom_we = 1'b1;
      S_IDLE:  busy = 1'b0;
      S_DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        cpu_reset = 1'b0;
      end
      S_ERR: begin
        busy  = 1'b0;
        error = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule
